// File: rtl/poly_voice_engine_if.sv
// Note command channel: the master offers a note-on/off command and the
// engine accepts it when valid and ready are both high.
interface poly_voice_engine_if #(
    parameter int unsigned PHASE_W_P = 24
);
    logic                 valid;
    logic                 ready;
    logic                 on;
    logic [3:0]           key;
    logic [PHASE_W_P-1:0] inc;
    logic [1:0]           octave;

    modport master (output valid, on, key, inc, octave, input ready);
    modport slave  (input valid, on, key, inc, octave, output ready);
endinterface

// File: rtl/poly_voice_engine.sv
// Polyphonic tone generator: VOICES_P voices with phase accumulator, waveform and
// linear attack/release envelope, swept one voice per cycle and mixed per sample tick.
module poly_voice_engine #(
    parameter int unsigned VOICES_P   = 4,
    parameter int unsigned WIDTH_P    = 24,
    parameter int unsigned PHASE_W_P  = 24,
    parameter int unsigned ENV_W_P    = 8,
    parameter int unsigned ATK_STEP_P = 16,
    parameter int unsigned REL_STEP_P = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sample_tick_i,
    poly_voice_engine_if.slave  note_io,
    input  logic [1:0]          wave_sel_i,
    output logic [WIDTH_P-1:0]  sample_o,
    output logic                sample_valid_o,
    output logic [VOICES_P-1:0] active_o,
    output logic                dropped_o
);
    localparam int unsigned VW = $clog2(VOICES_P);
    localparam int unsigned AW = WIDTH_P + VW;
    localparam int unsigned PW = WIDTH_P + ENV_W_P + 1;
    localparam logic [ENV_W_P-1:0] ENV_MAX = '1;
    localparam logic [WIDTH_P-1:0] SQ_POS  = {1'b0, {(WIDTH_P - 1){1'b1}}};
    localparam logic [WIDTH_P-1:0] SQ_NEG  = {1'b1, {(WIDTH_P - 2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StAttack, StSustain, StRelease} voice_st_e;

    voice_st_e            r_state   [VOICES_P];
    voice_st_e            w_state_d [VOICES_P];
    logic [3:0]           r_key     [VOICES_P];
    logic [3:0]           w_key_d   [VOICES_P];
    logic [PHASE_W_P-1:0] r_inc     [VOICES_P];
    logic [PHASE_W_P-1:0] w_inc_d   [VOICES_P];
    logic [PHASE_W_P-1:0] r_phase   [VOICES_P];
    logic [PHASE_W_P-1:0] w_phase_d [VOICES_P];
    logic [ENV_W_P-1:0]   r_env     [VOICES_P];
    logic [ENV_W_P-1:0]   w_env_d   [VOICES_P];

    logic                 r_busy;
    logic [VW:0]          r_idx;
    logic signed [AW-1:0] r_acc;
    logic [WIDTH_P-1:0]   r_sample;
    logic                 r_valid;
    logic                 r_dropped;

    logic                 w_xfer;
    logic                 w_start;
    logic                 w_sweep;
    logic [VW-1:0]        w_vidx;
    logic                 w_hit;
    logic                 w_free;
    logic                 w_steal;
    logic                 w_alloc_ok;
    logic [VW-1:0]        w_hit_idx;
    logic [VW-1:0]        w_free_idx;
    logic [VW-1:0]        w_steal_idx;
    logic [VW-1:0]        w_alloc_idx;
    logic [PHASE_W_P-1:0] w_inc_oct;

    voice_st_e             w_cur_st;
    voice_st_e             w_st_nxt;
    logic [ENV_W_P-1:0]    w_env_nxt;
    logic [PHASE_W_P-1:0]  w_phase_nxt;
    logic [31:0]           w_atk_sum;
    logic [WIDTH_P-1:0]    w_p;
    logic [WIDTH_P-2:0]    w_q;
    logic signed [WIDTH_P-1:0] w_wave;
    logic signed [PW-1:0]  w_prod;
    logic signed [AW-1:0]  w_contrib;
    logic signed [AW-1:0]  w_acc_nxt;

    assign note_io.ready  = ~r_busy;
    assign w_xfer         = note_io.valid & ~r_busy;
    assign w_start        = sample_tick_i & ~r_busy;
    assign w_sweep        = r_busy & ~r_idx[VW];
    assign w_vidx         = r_idx[VW-1:0];
    assign sample_o       = r_sample;
    assign sample_valid_o = r_valid;
    assign dropped_o      = r_dropped;

    // Allocation priority: same key, then lowest idle, then lowest releasing voice.
    always_comb begin
        w_hit       = 1'b0;
        w_free      = 1'b0;
        w_steal     = 1'b0;
        w_hit_idx   = '0;
        w_free_idx  = '0;
        w_steal_idx = '0;
        for (int k = int'(VOICES_P) - 1; k >= 0; k--) begin
            if (r_state[k] != StIdle && r_key[k] == note_io.key) begin
                w_hit     = 1'b1;
                w_hit_idx = VW'(k);
            end
            if (r_state[k] == StIdle) begin
                w_free     = 1'b1;
                w_free_idx = VW'(k);
            end
            if (r_state[k] == StRelease) begin
                w_steal     = 1'b1;
                w_steal_idx = VW'(k);
            end
        end
        w_alloc_ok  = w_hit | w_free | w_steal;
        w_alloc_idx = w_hit ? w_hit_idx : (w_free ? w_free_idx : w_steal_idx);
        case (note_io.octave)
            2'b01:   w_inc_oct = note_io.inc << 1;
            2'b10:   w_inc_oct = note_io.inc >> 1;
            default: w_inc_oct = note_io.inc;
        endcase
    end

    // Per-sweep update of the voice currently addressed by the sweep index.
    always_comb begin
        w_cur_st    = r_state[w_vidx];
        w_st_nxt    = w_cur_st;
        w_env_nxt   = r_env[w_vidx];
        w_phase_nxt = r_phase[w_vidx] + r_inc[w_vidx];
        w_atk_sum   = 32'(r_env[w_vidx]) + ATK_STEP_P;
        case (w_cur_st)
            StAttack: begin
                if (w_atk_sum >= 32'(ENV_MAX)) begin
                    w_env_nxt = ENV_MAX;
                    w_st_nxt  = StSustain;
                end else begin
                    w_env_nxt = ENV_W_P'(w_atk_sum);
                end
            end
            StRelease: begin
                if (32'(r_env[w_vidx]) <= REL_STEP_P) begin
                    w_env_nxt = '0;
                    w_st_nxt  = StIdle;
                end else begin
                    w_env_nxt = r_env[w_vidx] - ENV_W_P'(REL_STEP_P);
                end
            end
            default: ;
        endcase

        w_p = w_phase_nxt[PHASE_W_P-1 -: WIDTH_P];
        w_q = w_p[WIDTH_P-1] ? ~w_p[WIDTH_P-2:0] : w_p[WIDTH_P-2:0];
        case (wave_sel_i)
            2'b00:   w_wave = w_p[WIDTH_P-1] ? SQ_NEG : SQ_POS;
            2'b01:   w_wave = {~w_p[WIDTH_P-1], w_p[WIDTH_P-2:0]};
            2'b10:   w_wave = {~w_q[WIDTH_P-2], w_q[WIDTH_P-3:0], 1'b0};
            default: w_wave = '0;
        endcase

        w_prod    = {{(ENV_W_P + 1){w_wave[WIDTH_P-1]}}, w_wave}
                  * {{(WIDTH_P + 1){1'b0}}, w_env_nxt};
        w_contrib = (w_cur_st == StIdle) ? '0 : AW'(w_prod >>> ENV_W_P);
        w_acc_nxt = r_acc + w_contrib;
    end

    // Voice FSM next state: commands only land while idle, the sweep only while busy.
    always_comb begin
        w_state_d = r_state;
        w_key_d   = r_key;
        w_inc_d   = r_inc;
        w_phase_d = r_phase;
        w_env_d   = r_env;
        if (w_xfer) begin
            if (note_io.on) begin
                if (w_alloc_ok) begin
                    w_state_d[w_alloc_idx] = StAttack;
                    w_key_d[w_alloc_idx]   = note_io.key;
                    w_inc_d[w_alloc_idx]   = w_inc_oct;
                    w_phase_d[w_alloc_idx] = '0;
                    w_env_d[w_alloc_idx]   = '0;
                end
            end else if (w_hit && (r_state[w_hit_idx] == StAttack ||
                                   r_state[w_hit_idx] == StSustain)) begin
                w_state_d[w_hit_idx] = StRelease;
            end
        end
        if (w_sweep && w_cur_st != StIdle) begin
            w_state_d[w_vidx] = w_st_nxt;
            w_env_d[w_vidx]   = w_env_nxt;
            w_phase_d[w_vidx] = w_phase_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(VOICES_P); k++) begin
                r_state[k] <= StIdle;
                r_key[k]   <= '0;
                r_inc[k]   <= '0;
                r_phase[k] <= '0;
                r_env[k]   <= '0;
            end
        end else begin
            r_state <= w_state_d;
            r_key   <= w_key_d;
            r_inc   <= w_inc_d;
            r_phase <= w_phase_d;
            r_env   <= w_env_d;
        end
    end

    always_comb begin
        active_o = '0;
        for (int k = 0; k < int'(VOICES_P); k++) begin
            active_o[k] = (r_state[k] != StIdle);
        end
    end

    // Sweep control: busy covers the VOICES_P voice cycles plus the output cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy    <= 1'b0;
            r_idx     <= '0;
            r_acc     <= '0;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_dropped <= w_xfer & note_io.on & ~w_alloc_ok;
            if (w_start) begin
                r_busy <= 1'b1;
                r_idx  <= '0;
                r_acc  <= '0;
            end else if (r_busy) begin
                r_idx <= r_idx + (VW + 1)'(1);
                if (r_idx[VW]) begin
                    r_busy <= 1'b0;
                end else begin
                    r_acc <= w_acc_nxt;
                    if (&w_vidx) begin
                        r_sample <= WIDTH_P'(w_acc_nxt >>> VW);
                        r_valid  <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_poly_voice_engine.sv
// Self-checking bench for poly_voice_engine: behavioural voice model feeding a
// sample scoreboard, a command table, and hand sequences for busy/reset corners.
module tb_poly_voice_engine;
    localparam longint HALF = 64'd8388608;
    localparam longint FULL = 64'd16777216;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_tick = 1'b0;
    logic [1:0]  wave_sel = 2'b00;
    logic [23:0] sample;
    logic        sample_valid;
    logic [3:0]  active;
    logic        dropped;

    int checks = 0;
    int errors = 0;
    longint exp_q[$];

    int m_state [4];  // 0 idle, 1 attack, 2 sustain, 3 release
    int m_env   [4];
    int m_phase [4];
    int m_key   [4];
    int m_inc   [4];

    typedef struct {
        logic       on;
        int         key;
        int         inc;
        int         oct;
        int         wave;
        int         ticks;
        logic [3:0] exp_act;
        logic       exp_drop;
    } cmd_row_t;

    cmd_row_t rows [7];

    poly_voice_engine_if #(.PHASE_W_P(24)) note_if ();

    poly_voice_engine #(
        .VOICES_P  (4),
        .WIDTH_P   (24),
        .PHASE_W_P (24),
        .ENV_W_P   (8),
        .ATK_STEP_P(16),
        .REL_STEP_P(8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sample_tick_i (sample_tick),
        .note_io       (note_if),
        .wave_sel_i    (wave_sel),
        .sample_o      (sample),
        .sample_valid_o(sample_valid),
        .active_o      (active),
        .dropped_o     (dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            m_state[k] = 0;
            m_env[k]   = 0;
            m_phase[k] = 0;
            m_key[k]   = 0;
            m_inc[k]   = 0;
        end
    endfunction

    function automatic int model_cmd(input int on, input int key, input int inc, input int oct);
        int tgt = -1;
        if (on != 0) begin
            for (int k = 0; k < 4; k++) if (tgt < 0 && m_state[k] != 0 && m_key[k] == key) tgt = k;
            for (int k = 0; k < 4; k++) if (tgt < 0 && m_state[k] == 0) tgt = k;
            for (int k = 0; k < 4; k++) if (tgt < 0 && m_state[k] == 3) tgt = k;
            if (tgt < 0) return 1;
            m_state[tgt] = 1;
            m_env[tgt]   = 0;
            m_phase[tgt] = 0;
            m_key[tgt]   = key;
            if (oct == 1)      m_inc[tgt] = int'((longint'(inc) * 2) % FULL);
            else if (oct == 2) m_inc[tgt] = inc / 2;
            else               m_inc[tgt] = inc;
        end else begin
            for (int k = 0; k < 4; k++)
                if (m_key[k] == key && (m_state[k] == 1 || m_state[k] == 2)) m_state[k] = 3;
        end
        return 0;
    endfunction

    function automatic longint wave_val(input longint p, input int sel);
        longint q;
        case (sel)
            0: return (p < HALF) ? (HALF - 1) : -(HALF - 1);
            1: return p - HALF;
            2: begin
                q = (p < HALF) ? p : (FULL - 1 - p);
                return 2 * q - HALF;
            end
            default: return 0;
        endcase
    endfunction

    function automatic longint model_sweep(input int sel);
        longint acc = 0;
        for (int k = 0; k < 4; k++) begin
            if (m_state[k] != 0) begin
                m_phase[k] = int'((longint'(m_phase[k]) + m_inc[k]) % FULL);
                if (m_state[k] == 1) begin
                    m_env[k] += 16;
                    if (m_env[k] >= 255) begin
                        m_env[k]   = 255;
                        m_state[k] = 2;
                    end
                end else if (m_state[k] == 3) begin
                    m_env[k] -= 8;
                    if (m_env[k] <= 0) begin
                        m_env[k]   = 0;
                        m_state[k] = 0;
                    end
                end
                acc += (wave_val(longint'(m_phase[k]), sel) * m_env[k]) >>> 8;
            end
        end
        return acc >>> 2;
    endfunction

    // Entered at #1 into the cycle after the tick; returns at the valid cycle's negedge.
    task automatic collect(input string tag, output longint got, output logic a1, output logic a2);
        int lat = 0;
        longint exp = 0;
        a1 = 1'b0;
        a2 = 1'b0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) a1 = active[0];
            if (c == 2) a2 = active[0];
            if (sample_valid) lat = c;
        end
        check({tag, " latency"}, lat, 5);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        got = longint'($signed(sample));
        check({tag, " sample"}, got, exp);
    endtask

    task automatic do_tick(input string tag, output longint got, output logic a1,
                           output logic a2);
        int n = 0;
        @(posedge clk); #1;
        while (!note_if.ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        sample_tick = 1'b1;
        exp_q.push_back(model_sweep(int'(wave_sel)));
        @(posedge clk); #1;
        sample_tick = 1'b0;
        collect(tag, got, a1, a2);
    endtask

    task automatic send_cmd(input int on, input int key, input int inc, input int oct,
                            output logic [3:0] act, output logic drp);
        int n = 0;
        int unused_drop;
        @(posedge clk); #1;
        note_if.valid  = 1'b1;
        note_if.on     = (on != 0);
        note_if.key    = 4'(key);
        note_if.inc    = 24'(inc);
        note_if.octave = 2'(oct);
        @(negedge clk);
        while (!note_if.ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("cmd handshake timeout", longint'(note_if.ready), 1);
        @(posedge clk);
        unused_drop = model_cmd(on, key, inc, oct);
        #1;
        note_if.valid = 1'b0;
        @(negedge clk);
        act = active;
        drp = dropped;
    endtask

    task automatic hard_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    initial begin
        longint     got;
        logic       a1, a2, drp;
        logic [3:0] act;
        int         nvalid;
        int         d;

        rows[0] = '{1'b1, 1, 'h010000, 0, 1, 0, 4'b0001, 1'b0};
        rows[1] = '{1'b1, 2, 'h020000, 0, 1, 0, 4'b0011, 1'b0};
        rows[2] = '{1'b1, 3, 'h030000, 2, 1, 0, 4'b0111, 1'b0};
        rows[3] = '{1'b1, 4, 'h008000, 1, 1, 3, 4'b1111, 1'b0};
        rows[4] = '{1'b1, 5, 'h011000, 0, 1, 0, 4'b1111, 1'b1};
        rows[5] = '{1'b0, 2, 0,        0, 1, 2, 4'b1111, 1'b0};
        rows[6] = '{1'b1, 6, 'h022000, 0, 2, 4, 4'b1111, 1'b0};

        note_if.valid  = 1'b0;
        note_if.on     = 1'b0;
        note_if.key    = 4'd0;
        note_if.inc    = 24'd0;
        note_if.octave = 2'd0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset sample_o", longint'(sample), 0);
        check("reset sample_valid_o", longint'(sample_valid), 0);
        check("reset dropped_o", longint'(dropped), 0);
        check("reset active_o", longint'(active), 0);
        check("reset note_ready_o", longint'(note_if.ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        nvalid = 0;
        repeat (20) begin
            @(negedge clk);
            if (sample_valid) nvalid++;
        end
        check("idle no sample_valid", nvalid, 0);
        check("idle sample_o", longint'(sample), 0);
        check("idle note_ready_o", longint'(note_if.ready), 1);

        // Square wave attack to sustain
        wave_sel = 2'b00;
        send_cmd(1, 1, 'h010000, 0, act, drp);
        check("square note-on active", longint'(act), 1);
        check("square note-on dropped", longint'(drp), 0);
        for (int i = 0; i < 16; i++) do_tick("square", got, a1, a2);
        check("square sustain value", got, 2088959);

        // Retrigger in sustain
        send_cmd(1, 1, 'h010000, 0, act, drp);
        check("retrigger active", longint'(act), 1);
        do_tick("retrigger", got, a1, a2);
        check("retrigger env16 value", got, 131071);
        repeat (15) do_tick("reattack", got, a1, a2);

        // Release from 255 down to idle
        send_cmd(0, 1, 0, 0, act, drp);
        check("note-off still active", longint'(act), 1);
        for (int i = 0; i < 31; i++) do_tick("release", got, a1, a2);
        check("release env7 value", got, 57343);
        do_tick("release end", got, a1, a2);
        check("release end value", got, 0);
        check("active bit0 at voice-0 cycle", longint'(a1), 1);
        check("active bit0 after voice-0 edge", longint'(a2), 0);
        check("release end active_o", longint'(active), 0);

        // Command table: allocation, drop, steal
        for (int r = 0; r < 7; r++) begin
            wave_sel = 2'(rows[r].wave);
            send_cmd(int'(rows[r].on), rows[r].key, rows[r].inc, rows[r].oct, act, drp);
            check($sformatf("row%0d active_o", r), longint'(act), longint'(rows[r].exp_act));
            check($sformatf("row%0d dropped_o", r), longint'(drp), longint'(rows[r].exp_drop));
            for (int t = 0; t < rows[r].ticks; t++)
                do_tick($sformatf("row%0d tick", r), got, a1, a2);
        end
        wave_sel = 2'b00;
        repeat (2) do_tick("mix square", got, a1, a2);
        wave_sel = 2'b11;
        do_tick("silent", got, a1, a2);
        check("silent value", got, 0);

        // Reset in the middle of a sweep
        @(posedge clk); #1;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        nvalid = 0;
        repeat (12) begin
            @(negedge clk);
            if (sample_valid) nvalid++;
        end
        check("mid-sweep reset no valid", nvalid, 0);
        check("mid-sweep reset active_o", longint'(active), 0);
        check("mid-sweep reset sample_o", longint'(sample), 0);

        // Tick during busy is ignored
        wave_sel = 2'b10;
        send_cmd(1, 7, 'h012345, 0, act, drp);
        check("key7 active", longint'(act), 1);
        fork
            do_tick("busy tick", got, a1, a2);
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                @(posedge clk); #1;
                sample_tick = 1'b1;
                @(posedge clk); #1;
                sample_tick = 1'b0;
            end
        join
        nvalid = 0;
        repeat (12) begin
            @(negedge clk);
            if (sample_valid) nvalid++;
        end
        check("ignored tick no extra valid", nvalid, 0);

        // Command offered during busy is held until the sweep ends
        fork
            do_tick("held cmd tick", got, a1, a2);
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                @(negedge clk);
                check("note_ready_o low while busy", longint'(note_if.ready), 0);
                send_cmd(1, 8, 'h00abcd, 0, act, drp);
                check("held cmd active", longint'(act), 3);
                check("held cmd dropped", longint'(drp), 0);
            end
        join
        repeat (2) do_tick("after held cmd", got, a1, a2);

        // Tick and transfer in the same cycle, octave up
        hard_reset();
        wave_sel = 2'b01;
        @(posedge clk); #1;
        note_if.valid  = 1'b1;
        note_if.on     = 1'b1;
        note_if.key    = 4'd3;
        note_if.inc    = 24'h010000;
        note_if.octave = 2'b01;
        sample_tick    = 1'b1;
        @(negedge clk);
        check("combo ready", longint'(note_if.ready), 1);
        @(posedge clk);
        d = model_cmd(1, 3, 'h010000, 1);
        exp_q.push_back(model_sweep(1));
        #1;
        note_if.valid = 1'b0;
        sample_tick   = 1'b0;
        collect("combo", got, a1, a2);
        check("octave up first sample", got, -129024);
        do_tick("octave", got, a1, a2);
        check("octave up second sample", got, -253952);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/poly_voice_engine.md
# poly_voice_engine

Parametrised polyphonic tone generator that replaces the single keypad-driven clock divider and fixed-waveform path feeding the I2S transmitter. It holds VOICES_P independent voices, each with a phase accumulator, selectable waveform and linear attack/release envelope. Note-on/off commands arrive over a valid/ready handshake, and voices are allocated automatically. On every audio sample strobe the voices are swept one per cycle, and their outputs are mixed into one signed sample for the codec's left/right data inputs.

## Interface
- VOICES_P, 4: voice count, power of two, 2..16
- WIDTH_P, 24: output sample width, signed
- PHASE_W_P, 24: phase accumulator width, must be >= WIDTH_P
- ENV_W_P, 8: envelope level width, unsigned
- ATK_STEP_P, 16: envelope increment per sample in ATTACK
- REL_STEP_P, 8: envelope decrement per sample in RELEASE

Ports:
- clk_i  in  1  system clock (12.288 MHz domain)
- rst_i  in  1  reset; asynchronous and active-high
- sample_tick_i  in  1  one-cycle strobe, one per output sample (48 kHz)
- note_valid_i  in  1  note command valid
- note_ready_o  out  1  command accepted when valid&ready
- note_on_i  in  1  1 = note-on, 0 = note-off
- note_key_i  in  4  key code identifying the note
- note_inc_i  in  PHASE_W_P  phase increment per sample
- octave_i  in  2  00/11 none, 01 increment<<1, 10 increment>>1; applied at note-on
- wave_sel_i  in  2  00 square, 01 saw, 10 triangle, 11 silent; live, global
- sample_o  out  WIDTH_P  mixed signed sample
- sample_valid_o  out  1  one-cycle pulse when sample_o updates
- active_o  out  VOICES_P  bit k = voice k not IDLE
- dropped_o  out  1  one-cycle pulse when a note-on found no voice

## Operation
- Per-voice state: key, increment, phase, envelope level, and FSM state (IDLE, ATTACK, SUSTAIN, RELEASE).
- Note-on allocation, evaluated in priority order:
  - If a non-IDLE voice holds the key, retrigger it.
  - Otherwise take the lowest-index IDLE voice.
  - Otherwise steal the lowest-index RELEASE voice.
  - Otherwise drop the command and pulse dropped_o.
- On allocation or retrigger:
  - phase <= 0, env <= 0, state <= ATTACK.
  - Increment is stored after the octave_i shift.
- Note-off:
  - The matching ATTACK or SUSTAIN voice goes to RELEASE from its current level.
  - No match, or a match already in RELEASE: no effect.
- Envelope update, once per sweep per non-IDLE voice:
  - ATTACK: env += ATK_STEP_P, saturating at 2^ENV_W_P-1; on saturation, state <= SUSTAIN.
  - SUSTAIN: env holds.
  - RELEASE: env -= REL_STEP_P, clamped at 0; on reaching 0, state <= IDLE.
- Phase update: phase += inc mod 2^PHASE_W_P, for non-IDLE voices only. Let p be the top WIDTH_P bits of phase and m = p[MSB].
- Waveforms (W = WIDTH_P):
  - Square: m=0 gives +(2^(W-1)-1); m=1 gives -(2^(W-1)-1).
  - Saw: p with the MSB inverted, read as signed.
  - Triangle: q = m ? ~p[W-2:0] : p[W-2:0]; result is {q,0} with the MSB inverted, read as signed.
  - Silent: 0.
- Voice output: (wave × env) >>> ENV_W_P, signed. IDLE voices contribute 0.
- Mixing:
  - Accumulator width is WIDTH_P + log2(VOICES_P); it never overflows.
  - sample_o = accumulator >>> log2(VOICES_P), with no clipping.
- Phase, envelope and output all use values updated in the current sweep: new phase and new env.

## Timing
- Reset values:
  - All voices IDLE, phase 0, env 0.
  - sample_o 0, sample_valid_o 0, dropped_o 0, active_o 0, note_ready_o 1.
  - Reset mid-sweep aborts the sweep, and no sample_valid_o is produced.
- A tick at cycle T starts a sweep: voice k is processed in cycle T+1+k.
- sample_o is registered, and sample_valid_o is high in cycle T+VOICES_P+1 only.
- busy spans cycles T+1 through T+VOICES_P+1.
- note_ready_o = ~busy (combinational from registered busy).
- A command transfer updates voice state at the clock edge, and dropped_o pulses in the following cycle.
- A tick and a transfer in the same cycle: the command is applied first, and the sweep sees the new state.
- sample_tick_i while busy is ignored; tick spacing must exceed VOICES_P+1 cycles.
- active_o reflects state registers and changes at the edge that changes state.

## Test plan
All scenarios use default parameters.
- Reset → all outputs at their reset values; note_ready_o=1; no sample_valid_o for 20 idle ticks, and sample_o stays 0.
- Square, note-on key 1 with inc 0x010000 and octave 00, then 16 ticks → env 255 and SUSTAIN; sample_o = 2088959 (+max×255>>>8>>>2) while m=0; sample_valid_o arrives exactly 5 cycles after each tick.
- Four note-ons, keys 1–4 → active_o=1111; key 5 → dropped_o pulse, active_o unchanged; note-off key 2, then note-on key 6 → voice 1 is stolen and restarts at env 0.
- Retrigger key 1 while in SUSTAIN → same voice; the next sample after the following tick uses env 16 and phase = inc.
- Note-off in SUSTAIN (env 255) → 31 ticks reach env 7; the 32nd tick reaches 0 and IDLE, and active_o bit 0 clears at that sweep's voice-0 edge.
- Assert a tick during busy → ignored, with one sample_valid_o per accepted tick; note_valid_i during busy → note_ready_o=0 and the command is held until the sweep ends; octave 01 with inc 0x010000 → phase advances 0x020000 per sample.
